// File: rtl/matmul_host_feeder.sv
// Operand/result buffer between the HPS bus and the matmul engine: serves vec/mat words to the
// engine, kicks a run, drains the result vector into a host-readable buffer and raises irq.
module matmul_host_feeder #(
    parameter int VEC_BITS = 2,
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 4,
    parameter int OFF_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OFF_BITS+1:0]   host_addr,
    input  logic                  host_wr,
    input  logic [15:0]           host_wdata,
    input  logic                  host_rd,
    output logic [15:0]           host_rdata,
    output logic                  irq,
    output logic                  mm_start,
    input  logic                  mm_ready,
    output logic [15:0]           mm_data1,
    output logic [15:0]           mm_data2,
    output logic [COL_BITS-1:0]   mm_sel,
    input  logic [15:0]           mm_data_out,
    input  logic [VEC_BITS-1:0]   mm_sel_vec,
    input  logic [ROW_BITS-1:0]   mm_sel_row,
    input  logic [COL_BITS-1:0]   mm_sel_col
);

    localparam int MAT_BITS = ROW_BITS + COL_BITS;
    localparam int VEC_LEN  = 1 << VEC_BITS;
    localparam int MAT_LEN  = 1 << MAT_BITS;
    localparam int RES_LEN  = 1 << COL_BITS;

    typedef enum logic [2:0] {S_IDLE, S_KICK, S_WAIT_LO, S_WAIT_HI, S_DRAIN, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_vec   [VEC_LEN];
    logic [15:0]           r_mat   [MAT_LEN];
    logic [15:0]           r_res   [RES_LEN];
    logic [15:0]           r_stage [RES_LEN];
    logic [COL_BITS-1:0]   r_k;
    logic                  r_done;
    logic                  r_err;
    logic [15:0]           r_rdata;

    logic [1:0]            w_region;
    logic [OFF_BITS-1:0]   w_off;
    logic                  w_ctrl_hit, w_vec_hit, w_mat_hit, w_res_hit;
    logic                  w_busy, w_go, w_clr, w_op_wr, w_err_set, w_drain_last;
    logic [15:0]           w_rdata_nxt;

    assign w_region     = host_addr[OFF_BITS+1:OFF_BITS];
    assign w_off        = host_addr[OFF_BITS-1:0];
    assign w_ctrl_hit   = (w_region == 2'b00) && (w_off == '0);
    assign w_vec_hit    = (w_region == 2'b01) && ((w_off >> VEC_BITS) == '0);
    assign w_mat_hit    = (w_region == 2'b10) && ((w_off >> MAT_BITS) == '0);
    assign w_res_hit    = (w_region == 2'b11) && ((w_off >> COL_BITS) == '0);

    assign w_busy       = (r_state == S_KICK) || (r_state == S_WAIT_LO) ||
                          (r_state == S_WAIT_HI) || (r_state == S_DRAIN);
    assign w_go         = host_wr && w_ctrl_hit && host_wdata[0];
    assign w_clr        = host_wr && w_ctrl_hit && host_wdata[1];
    assign w_op_wr      = host_wr && (w_vec_hit || w_mat_hit);
    // Operands are frozen for the whole run so the engine never sees a half-updated matrix.
    assign w_err_set    = w_busy && (w_go || w_op_wr);
    assign w_drain_last = (r_state == S_DRAIN) && (r_k == '1);

    assign irq        = r_done && !w_busy;
    assign host_rdata = r_rdata;
    assign mm_data1   = r_vec[mm_sel_vec];
    assign mm_data2   = r_mat[{mm_sel_row, mm_sel_col}];

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        mm_start    = 1'b0;
        mm_sel      = '0;
        case (r_state)
            S_IDLE, S_DONE: if (w_go) w_state_nxt = S_KICK;
            S_KICK: begin
                mm_start    = 1'b1;
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: if (!mm_ready) w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (mm_ready) w_state_nxt = S_DRAIN;
            S_DRAIN: begin
                mm_sel = r_k;
                if (r_k == '1) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata_nxt = '0;
        case (w_region)
            2'b00: if (w_ctrl_hit) w_rdata_nxt = {13'b0, r_err, r_done, w_busy};
            2'b01: if (w_vec_hit)  w_rdata_nxt = r_vec[w_off[VEC_BITS-1:0]];
            2'b10: if (w_mat_hit)  w_rdata_nxt = r_mat[w_off[MAT_BITS-1:0]];
            default: if (w_res_hit) w_rdata_nxt = r_res[w_off[COL_BITS-1:0]];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= (r_state == S_DRAIN) ? r_k + 1'b1 : '0;
            if (host_rd) r_rdata <= w_rdata_nxt;
            if (w_clr) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_err_set)    r_err  <= 1'b1;
            if (w_drain_last) r_done <= 1'b1;
        end
    end

    // NOTE: the buffers are small register files, so they are reset like any other flop;
    // a RAM macro would not allow this.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VEC_LEN; i++) r_vec[i] <= '0;
            for (int i = 0; i < MAT_LEN; i++) r_mat[i] <= '0;
            for (int i = 0; i < RES_LEN; i++) begin
                r_res[i]   <= '0;
                r_stage[i] <= '0;
            end
        end else begin
            if (host_wr && w_vec_hit && !w_busy) r_vec[w_off[VEC_BITS-1:0]] <= host_wdata;
            if (host_wr && w_mat_hit && !w_busy) r_mat[w_off[MAT_BITS-1:0]] <= host_wdata;
            // Drain into staging so host reads keep returning the previous run until the last word lands.
            if (r_state == S_DRAIN) r_stage[r_k] <= mm_data_out;
            if (w_drain_last) begin
                for (int i = 0; i < RES_LEN - 1; i++) r_res[i] <= r_stage[i];
                r_res[RES_LEN-1] <= mm_data_out;
            end
        end
    end

endmodule

// File: tb/tb_matmul_host_feeder.sv
// Randomized self-checking bench: a behavioural engine answers the feeder's handshake and a
// plain-arithmetic matrix-vector model predicts every value the host reads back.
module tb_matmul_host_feeder;

    localparam int VB = 2;
    localparam int RB = 2;
    localparam int CB = 4;
    localparam int OB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [OB+1:0] host_addr = '0;
    logic          host_wr = 1'b0;
    logic [15:0]   host_wdata = '0;
    logic          host_rd = 1'b0;
    logic [15:0]   host_rdata;
    logic          irq;
    logic          mm_start;
    logic          mm_ready;
    logic [15:0]   mm_data1;
    logic [15:0]   mm_data2;
    logic [CB-1:0] mm_sel;
    logic [15:0]   mm_data_out;
    logic [VB-1:0] mm_sel_vec;
    logic [RB-1:0] mm_sel_row;
    logic [CB-1:0] mm_sel_col;

    always #5 clk = ~clk;

    matmul_host_feeder #(.VEC_BITS(VB), .ROW_BITS(RB), .COL_BITS(CB), .OFF_BITS(OB)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_wr(host_wr), .host_wdata(host_wdata),
        .host_rd(host_rd), .host_rdata(host_rdata), .irq(irq),
        .mm_start(mm_start), .mm_ready(mm_ready), .mm_data1(mm_data1), .mm_data2(mm_data2),
        .mm_sel(mm_sel), .mm_data_out(mm_data_out),
        .mm_sel_vec(mm_sel_vec), .mm_sel_row(mm_sel_row), .mm_sel_col(mm_sel_col)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural engine: fetch all operands, accumulate in Q8.8, report ready
    int                eng_ph;
    int                eng_wait;
    logic [5:0]        eng_idx;
    logic [5:0]        eng_nxt;
    logic signed [31:0] eng_acc [16];
    logic [15:0]       eng_res [16];

    assign eng_nxt     = eng_idx + 6'd1;
    assign mm_data_out = eng_res[mm_sel];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_ph     <= 0;
            eng_wait   <= 0;
            eng_idx    <= '0;
            mm_ready   <= 1'b1;
            mm_sel_vec <= '0;
            mm_sel_row <= '0;
            mm_sel_col <= '0;
            for (int j = 0; j < 16; j++) begin
                eng_acc[j] <= '0;
                eng_res[j] <= '0;
            end
        end else begin
            case (eng_ph)
                0: if (mm_start) begin
                    eng_ph   <= 1;
                    eng_wait <= int'($urandom_range(0, 2));
                end
                1: if (eng_wait == 0) begin
                    mm_ready   <= 1'b0;
                    eng_ph     <= 2;
                    eng_idx    <= '0;
                    mm_sel_vec <= '0;
                    mm_sel_row <= '0;
                    mm_sel_col <= '0;
                    for (int j = 0; j < 16; j++) eng_acc[j] <= '0;
                end else begin
                    eng_wait <= eng_wait - 1;
                end
                2: begin
                    eng_acc[eng_idx[3:0]] <= eng_acc[eng_idx[3:0]] +
                                             $signed(mm_data1) * $signed(mm_data2);
                    if (eng_idx == 6'd63) begin
                        eng_ph <= 3;
                    end else begin
                        eng_idx    <= eng_nxt;
                        mm_sel_vec <= eng_nxt[5:4];
                        mm_sel_row <= eng_nxt[5:4];
                        mm_sel_col <= eng_nxt[3:0];
                    end
                end
                default: begin
                    for (int j = 0; j < 16; j++) eng_res[j] <= eng_acc[j][23:8];
                    mm_ready <= 1'b1;
                    eng_ph   <= 0;
                end
            endcase
        end
    end

    int start_cnt = 0;
    int irq_cnt   = 0;
    always @(posedge clk) begin
        if (mm_start === 1'b1) start_cnt++;
        if (irq === 1'b1) irq_cnt++;
    end

    // ---------------- reference model of host-visible state
    logic [15:0] vec_m [4];
    logic [15:0] mat_m [64];
    logic [15:0] res_m [16];
    logic [15:0] res_old [16];
    logic        err_m, done_m;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++)  vec_m[i] = '0;
        for (int i = 0; i < 64; i++) mat_m[i] = '0;
        for (int i = 0; i < 16; i++) res_m[i] = '0;
        err_m  = 1'b0;
        done_m = 1'b0;
    endfunction

    function automatic void model_run();
        for (int j = 0; j < 16; j++) begin
            longint acc = 0;
            for (int i = 0; i < 4; i++)
                acc += longint'($signed(vec_m[i])) * longint'($signed(mat_m[i*16 + j]));
            res_m[j] = 16'(acc >>> 8);
        end
        done_m = 1'b1;
    endfunction

    // ---------------- host bus tasks (called just after a rising edge)
    task automatic host_write(input logic [1:0] rg, input int off, input logic [15:0] d);
        host_addr  = {rg, off[OB-1:0]};
        host_wdata = d;
        host_wr    = 1'b1;
        @(posedge clk); #1;
        host_wr    = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] rg, input int off, output logic [15:0] d);
        host_addr = {rg, off[OB-1:0]};
        host_rd   = 1'b1;
        @(posedge clk); #1;
        host_rd   = 1'b0;
        d         = host_rdata;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] rg, input int off,
                            input logic [15:0] exp);
        logic [15:0] d;
        host_read(rg, off, d);
        check($sformatf("%s[%0d]", tag, off), d, exp);
    endtask

    task automatic ctrl_chk(input string tag, input logic busy_exp);
        read_chk(tag, 2'b00, 0, {13'b0, err_m, done_m, busy_exp});
    endtask

    task automatic wait_irq(input string tag);
        int n = 0;
        while (irq !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_irq_seen"}, irq, 1'b1);
    endtask

    task automatic wait_ready(input logic lvl, input string tag);
        int n = 0;
        while (mm_ready !== lvl && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, mm_ready, lvl);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 4; i++)  read_chk({tag, "_vec"}, 2'b01, i, 16'h0);
        for (int i = 0; i < 64; i++) read_chk({tag, "_mat"}, 2'b10, i, 16'h0);
        for (int i = 0; i < 16; i++) read_chk({tag, "_res"}, 2'b11, i, 16'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int i0;
        logic [15:0] d;

        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        check("reset_irq", irq, 1'b0);
        check("reset_mm_start", mm_start, 1'b0);
        check("reset_mm_sel", mm_sel, '0);
        ctrl_chk("reset_ctrl", 1'b0);
        check_all_zero("reset");

        // directed run: identity-like vector picks row 0 of the matrix
        vec_m[0] = 16'h0100;
        host_write(2'b01, 0, 16'h0100);
        for (int j = 0; j < 16; j++) begin
            mat_m[j] = 16'(16'h0100 * j);
            host_write(2'b10, j, mat_m[j]);
        end
        s0 = start_cnt;
        host_write(2'b00, 0, 16'h0001);
        check("go_busy_irq_low", irq, 1'b0);
        wait_irq("run1");
        model_run();
        check("run1_start_pulses", start_cnt - s0, 1);
        ctrl_chk("run1_ctrl", 1'b0);
        for (int j = 0; j < 16; j++) read_chk("run1_res", 2'b11, j, res_m[j]);
        read_chk("run1_res_last", 2'b11, 15, 16'h0F00);

        // operand write while busy is dropped and flags err
        s0 = start_cnt;
        host_write(2'b00, 0, 16'h0001);
        host_write(2'b01, 2, 16'h0200);
        err_m = 1'b1;
        read_chk("busy_ctrl_bits", 2'b00, 0, {13'b0, 1'b1, done_m, 1'b1});
        wait_irq("run2");
        model_run();
        check("run2_start_pulses", start_cnt - s0, 1);
        read_chk("busy_write_dropped", 2'b01, 2, 16'h0000);
        ctrl_chk("run2_ctrl", 1'b0);
        for (int j = 0; j < 16; j++) read_chk("run2_res", 2'b11, j, res_m[j]);
        host_write(2'b00, 0, 16'h0002);
        err_m = 1'b0; done_m = 1'b0;
        ctrl_chk("clear_ctrl", 1'b0);
        check("clear_irq", irq, 1'b0);

        // go during drain is ignored but flags err
        s0 = start_cnt;
        host_write(2'b00, 0, 16'h0001);
        wait_ready(1'b0, "drain");
        wait_ready(1'b1, "drain");
        @(posedge clk); #1;
        check("in_drain_busy", irq, 1'b0);
        host_write(2'b00, 0, 16'h0001);
        err_m = 1'b1;
        wait_irq("run3");
        model_run();
        repeat (10) @(posedge clk);
        #1 check("drain_go_start_pulses", start_cnt - s0, 1);
        ctrl_chk("drain_go_ctrl", 1'b0);
        host_write(2'b00, 0, 16'h0002);
        err_m = 1'b0; done_m = 1'b0;
        ctrl_chk("clear2_ctrl", 1'b0);
        check("clear2_irq", irq, 1'b0);

        // address-map corner cases
        host_write(2'b01, 5, 16'hBEEF);
        read_chk("vec_oob", 2'b01, 5, 16'h0000);
        read_chk("mat_oob", 2'b10, 64, 16'h0000);
        read_chk("ctrl_oob", 2'b00, 1, 16'h0000);
        host_write(2'b11, 3, 16'h1234);
        read_chk("res_write_ignored", 2'b11, 3, res_m[3]);
        ctrl_chk("no_err_ctrl", 1'b0);
        host_addr  = {2'b01, 8'd1};
        host_wdata = 16'h7A5C;
        host_wr    = 1'b1;
        host_rd    = 1'b1;
        @(posedge clk); #1;
        host_wr = 1'b0;
        host_rd = 1'b0;
        check("wr_rd_old_data", host_rdata, vec_m[1]);
        vec_m[1] = 16'h7A5C;
        read_chk("wr_rd_new_data", 2'b01, 1, vec_m[1]);

        // randomized back-to-back runs from DONE
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 4; i++) begin
                vec_m[i] = 16'($urandom);
                host_write(2'b01, i, vec_m[i]);
            end
            for (int i = 0; i < 64; i++) begin
                mat_m[i] = 16'($urandom);
                host_write(2'b10, i, mat_m[i]);
            end
            for (int j = 0; j < 16; j++) res_old[j] = res_m[j];
            s0 = start_cnt;
            host_write(2'b00, 0, 16'h0001);
            for (int j = 0; j < 16; j++)
                read_chk($sformatf("rand%0d_old_res", it), 2'b11, j, res_old[j]);
            wait_irq($sformatf("rand%0d", it));
            model_run();
            check($sformatf("rand%0d_start_pulses", it), start_cnt - s0, 1);
            ctrl_chk($sformatf("rand%0d_ctrl", it), 1'b0);
            for (int j = 0; j < 16; j++)
                read_chk($sformatf("rand%0d_res", it), 2'b11, j, res_m[j]);
        end

        // reset while waiting for the engine
        host_write(2'b00, 0, 16'h0001);
        wait_ready(1'b0, "rst");
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_async_mm_start", mm_start, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        s0 = start_cnt;
        i0 = irq_cnt;
        repeat (150) @(posedge clk);
        #1;
        check("rst_no_irq", irq_cnt - i0, 0);
        check("rst_no_start", start_cnt - s0, 0);
        check("rst_mm_sel", mm_sel, '0);
        ctrl_chk("rst_ctrl", 1'b0);
        check_all_zero("rst");
        host_read(2'b00, 0, d);
        check("rst_final_ctrl", d, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
